// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier result path.
package mult_pkg;

    localparam int unsigned RESULT_W      = 16;
    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam logic [7:0]  DROP_MAX      = 8'hFF;

    typedef logic [RESULT_W-1:0] product_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with explicit occupancy counter.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic                     push_ok_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             pop_ok;
    logic             push_ok;
    logic             full;

    assign full    = (count_q == CntW'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o   = mem_q[rd_ptr_q];
    assign valid_o   = (count_q != '0);
    assign push_ok_o = push_ok;
    assign count_o   = count_q;
    assign full_o    = full;

endmodule

// File: rtl/mult_result_buffer.sv
// Collects multiplier products into a FWFT FIFO, keeping a saturating sum and a drop count.
module mult_result_buffer
    import mult_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned ACC_W = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   d_end_i,
    input  product_t               result_i,
    input  logic                   clear_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output product_t               out_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic [ACC_W-1:0]       acc_o,
    output logic                   acc_ovf_o,
    output logic [7:0]             drop_cnt_o
);

    logic             push_ok;
    logic             drop;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] result_ext;

    sync_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (d_end_i),
        .pop_i     (out_ready_i),
        .wdata_i   (result_i),
        .rdata_o   (out_data_o),
        .valid_o   (out_valid_o),
        .push_ok_o (push_ok),
        .count_o   (count_o),
        .full_o    (full_o)
    );

    assign drop       = d_end_i && !push_ok;
    assign result_ext = {{(ACC_W - RESULT_W){1'b0}}, result_i};
    assign sum        = {1'b0, acc_q} + {1'b0, result_ext};

    always_comb begin
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clear_i) begin
            // A product arriving with clear starts the new sum; a drop in that cycle still counts.
            acc_d  = d_end_i ? result_ext : '0;
            ovf_d  = 1'b0;
            drop_d = drop ? 8'd1 : 8'd0;
        end else begin
            if (d_end_i) begin
                acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                ovf_d = ovf_q | sum[ACC_W];
            end
            if (drop && (drop_q != DROP_MAX)) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign acc_o      = acc_q;
    assign acc_ovf_o  = ovf_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: doc/mult_result_buffer.md
# mult_result_buffer

Downstream collector for the shift-add multiplier. Samples the 16-bit product on each one-cycle `d_end` pulse and queues it in a small FIFO. Drains the FIFO to the consumer over a valid/ready handshake, so the multiplier never stalls. Also keeps a saturating running sum of all products and counts products lost to a full FIFO.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ACC_W`, 24: accumulator width; ≥17.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `d_end` in 1: product-done pulse from the multiplier; `result` is valid in this cycle.
- `result` in 16: unsigned product {A, Q}.
- `clear` in 1: synchronous clear of the accumulator, `acc_ovf` and `drop_cnt`. Does not affect the FIFO.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out 16: FIFO head; don't-care when `out_valid`=0.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `full` out 1: `count`==DEPTH.
- `acc` out ACC_W: saturating sum of sampled products.
- `acc_ovf` out 1: sticky saturation flag.
- `drop_cnt` out 8: saturating count of dropped products.

## Operation
- Push request = `d_end`. Pop = `out_valid` && `out_ready`.
- FIFO is first-word fall-through: `out_data` = mem[rd_ptr] combinationally; `out_valid` = (`count`≠0).
- Push when not full: write mem[wr_ptr] and advance wr_ptr.
- Push when full with no pop in the same cycle: the product is dropped and `drop_cnt` increments, saturating at 255.
- Push when full with a pop in the same cycle: push is accepted and `count` is unchanged.
- Push and pop when not full and not empty: both happen and `count` is unchanged.
- Push on empty: the entry becomes visible on `out_valid` in the next cycle. There is no same-cycle bypass.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Occupancy is held in a separate `count` register.
- Accumulator: on `d_end`, acc ← min(acc + zero-extended result, 2^ACC_W−1). This includes dropped products.
- If the sum saturates, `acc_ovf` ← 1 and stays set until `clear` or `rst`.
- `clear` and `d_end` in the same cycle: acc ← result, `acc_ovf` ← 0, `drop_cnt` ← 0. A drop in that cycle also counts, so `drop_cnt` ← 1.
- `clear` alone: acc, `acc_ovf` and `drop_cnt` go to 0.
- `out_ready` is ignored when the FIFO is empty.

## Timing
- Reset values: `out_valid`=0, `count`=0, `full`=0, `acc`=0, `acc_ovf`=0, `drop_cnt`=0, pointers=0.
- `out_data` resets to don't-care. The bench must not check it while `out_valid`=0.
- Latency from `d_end` to `out_valid` on an empty FIFO: 1 cycle.
- `acc` reflects a product 1 cycle after its `d_end`.
- Throughput: one push and one pop per cycle. Back-to-back `d_end` must be handled, even though the multiplier cannot issue faster than about every 18 cycles.
- `rst` mid-operation: all queued entries are discarded immediately and nothing is emitted afterwards.
- Handshake: once `out_valid` is asserted, it and `out_data` stay stable until popped. This holds because pushes never alter the head.

## Structure
- Shared package `mult_pkg`:
  - `RESULT_W`=16.
  - Default `DEPTH`.
  - `DROP_MAX`=8'hFF.
  - `typedef logic [RESULT_W-1:0] product_t`.
- One sub-module, `sync_fifo`: parameterised width/depth; FWFT storage, pointers, count and full/empty.
- Accumulator, overflow flag and drop counter live in the top module.

## Test plan
- Reset, then `d_end` with `result`=16'h008F (13×11) → next cycle: `out_valid`=1, `out_data`=008F, `acc`=143, `count`=1. Pop → `count`=0.
- Four pushes 0001/0002/0003/0004 with `out_ready`=0 → `full`=1. Fifth push 0005 → `drop_cnt`=1, `acc`=15. Drain yields 1,2,3,4 in order.
- FIFO full, push 0009 and pop in the same cycle → `count` stays 4. Draining yields 2,3,4,9.
- Preload `acc` near max via repeated FE01 (255×255) pushes with ACC_W=17 → `acc`=1FFFF, `acc_ovf`=1. `clear` together with `d_end` 0010 → `acc`=0010, `acc_ovf`=0.
- Assert `rst` with 3 entries queued → `out_valid`=0 and `count`=0 immediately. First push after reset returns only the new value.
- Random `out_ready` backpressure over 200 products from a multiplier model → output order and values match, and drops plus pops equal pushes.
